// File: rtl/saber_centroid.sv
// saber_centroid: per-frame centroid of saber-masked pixels via accumulation and restoring division.
// Rev 1.0
`default_nettype none

module saber_centroid #(
  parameter int MIN_PIXELS = 16,
  parameter int COUNT_W    = 20,
  parameter int SUM_W      = 32
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [10:0] x_in,
  input  logic [9:0]  y_in,
  input  logic        valid_in,
  input  logic        mask_in,
  input  logic        tabulate_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        found_out,
  output logic        valid_out,
  output logic        busy_out
);

  localparam int STEP_W = $clog2(SUM_W);
  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(SUM_W - 1);
  localparam logic [COUNT_W-1:0] MIN_CNT   = COUNT_W'(MIN_PIXELS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    SKIP   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [SUM_W-1:0]   sum_x, sum_y;
  logic [COUNT_W-1:0] count;
  logic [SUM_W-1:0]   quo_x, quo_y;
  logic [COUNT_W-1:0] rem_x, rem_y, divisor;
  logic [STEP_W-1:0]  step;
  logic               divide_sel;

  logic pixel, count_max, enough, last_step;
  logic unused_quo;

  assign pixel      = valid_in & mask_in;
  assign count_max  = &count;
  assign enough     = (count >= MIN_CNT);
  assign last_step  = (step == STEP_LAST);
  assign busy_out   = (state != IDLE);
  assign unused_quo = ^{quo_x[SUM_W-1:11], quo_y[SUM_W-1:10]};

  // One restoring step: shift the next dividend bit into the remainder and
  // shift the quotient bit into the freed LSB of the dividend register.
  function automatic logic [COUNT_W+SUM_W-1:0] div_step(
    input logic [COUNT_W-1:0] rem,
    input logic [SUM_W-1:0]   quo,
    input logic [COUNT_W-1:0] dvs
  );
    logic [COUNT_W:0] trial;
    trial = {rem, quo[SUM_W-1]};
    if (trial >= {1'b0, dvs}) begin
      trial = trial - {1'b0, dvs};
      return {trial[COUNT_W-1:0], quo[SUM_W-2:0], 1'b1};
    end
    return {trial[COUNT_W-1:0], quo[SUM_W-2:0], 1'b0};
  endfunction

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (tabulate_in) state_nxt = enough ? DIVIDE : SKIP;
      DIVIDE, SKIP: if (last_step) state_nxt = DONE;
      DONE:        state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // Tabulate always restarts the frame, busy or not; a pixel in that cycle seeds it.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sum_x <= '0;
      sum_y <= '0;
      count <= '0;
    end else if (tabulate_in) begin
      sum_x <= pixel ? SUM_W'(x_in) : '0;
      sum_y <= pixel ? SUM_W'(y_in) : '0;
      count <= pixel ? COUNT_W'(1) : '0;
    end else if (pixel) begin
      sum_x <= sum_x + SUM_W'(x_in);
      sum_y <= sum_y + SUM_W'(y_in);
      if (!count_max) count <= count + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      quo_x      <= '0;
      quo_y      <= '0;
      rem_x      <= '0;
      rem_y      <= '0;
      divisor    <= '0;
      step       <= '0;
      divide_sel <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tabulate_in) begin
            quo_x      <= sum_x;
            quo_y      <= sum_y;
            rem_x      <= '0;
            rem_y      <= '0;
            divisor    <= count;
            step       <= '0;
            divide_sel <= enough;
          end
        end
        DIVIDE: begin
          {rem_x, quo_x} <= div_step(rem_x, quo_x, divisor);
          {rem_y, quo_y} <= div_step(rem_y, quo_y, divisor);
          step           <= step + 1'b1;
        end
        SKIP:    step <= step + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      x_out     <= '0;
      y_out     <= '0;
      found_out <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (state == DONE) begin
        valid_out <= 1'b1;
        found_out <= divide_sel;
        if (divide_sel) begin
          x_out <= quo_x[10:0];
          y_out <= quo_y[9:0];
        end
      end
    end
  end

endmodule

`default_nettype wire
